// File: rtl/bp_be_dcache_resp_checker.sv
// In-order load-response scoreboard: expected values are queued at issue and compared against D$ responses.
// Optional build macro BP_BE_DCACHE_RESP_CHECKER_STOP_ON_ERR_EN: the first mismatch or unexpected response forces FAIL.

module bp_be_dcache_resp_checker #(
    parameter int dword_width_p = 64,
    parameter int els_p         = 8,
    parameter int timeout_p     = 1024,
    parameter int cnt_width_p   = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         exp_v_i,
    input  logic [dword_width_p-1:0]     exp_data_i,
    input  logic [dword_width_p-1:0]     exp_mask_i,
    output logic                         exp_ready_o,

    input  logic                         resp_v_i,
    input  logic [dword_width_p-1:0]     resp_data_i,
    output logic                         resp_ready_o,

    input  logic                         done_i,

    output logic [$clog2(els_p+1)-1:0]   outstanding_o,
    output logic [cnt_width_p-1:0]       match_count_o,
    output logic [cnt_width_p-1:0]       mismatch_count_o,
    output logic [dword_width_p-1:0]     first_err_exp_o,
    output logic [dword_width_p-1:0]     first_err_data_o,
    output logic                         unexpected_o,
    output logic                         timeout_o,
    output logic                         pass_o,
    output logic                         fail_o
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p + 1);
    localparam int timer_width_lp = $clog2(timeout_p);

    localparam logic [2:0] state_idle_lp  = 3'd0;
    localparam logic [2:0] state_run_lp   = 3'd1;
    localparam logic [2:0] state_drain_lp = 3'd2;
    localparam logic [2:0] state_pass_lp  = 3'd3;
    localparam logic [2:0] state_fail_lp  = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [count_width_lp-1:0]  count_q, count_d;
    logic [ptr_width_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [timer_width_lp-1:0]  timer_q, timer_d;
    logic [cnt_width_p-1:0]     match_cnt_q, match_cnt_d;
    logic [cnt_width_p-1:0]     mismatch_cnt_q, mismatch_cnt_d;
    logic [dword_width_p-1:0]   fe_exp_q, fe_exp_d;
    logic [dword_width_p-1:0]   fe_data_q, fe_data_d;
    logic                       unexp_q, unexp_d;
    logic                       timeout_q, timeout_d;
    logic                       pass_q, fail_q;

    logic [dword_width_p-1:0]   data_mem [els_p];
    logic [dword_width_p-1:0]   mask_mem [els_p];

    logic                       active;
    logic                       fifo_empty;
    logic                       push, accept, pop;
    logic                       unexp_now, mismatch_now, match_now, err_now;
    logic                       first_err;
    logic                       timeout_hit;
    logic                       stop_err;
    logic [dword_width_p-1:0]   head_data, head_mask;

    assign active     = (state_q == state_idle_lp) || (state_q == state_run_lp)
                     || (state_q == state_drain_lp);
    assign fifo_empty = (count_q == '0);

    assign exp_ready_o  = (count_q != count_width_lp'(els_p))
                       && ((state_q == state_idle_lp) || (state_q == state_run_lp));
    assign resp_ready_o = active;

    assign push      = exp_v_i & exp_ready_o;
    assign accept    = resp_v_i & resp_ready_o;
    assign pop       = accept & ~fifo_empty;
    assign unexp_now = accept & fifo_empty;

    assign head_data = data_mem[rd_ptr_q];
    assign head_mask = mask_mem[rd_ptr_q];

    assign mismatch_now = pop & (|((resp_data_i ^ head_data) & head_mask));
    assign match_now    = pop & ~mismatch_now;
    assign err_now      = mismatch_now | unexp_now;
    // Every error bumps the mismatch counter, which never returns to zero, so zero means "no error yet".
    assign first_err    = err_now & (mismatch_cnt_q == '0);

    assign timeout_hit = active && !fifo_empty && !pop
                      && (timer_q == timer_width_lp'(timeout_p - 2));

`ifdef BP_BE_DCACHE_RESP_CHECKER_STOP_ON_ERR_EN
    assign stop_err = err_now;
`else
    assign stop_err = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign wr_ptr_d = push ? wr_ptr_q + ptr_width_lp'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + ptr_width_lp'(1) : rd_ptr_q;

    always_comb begin
        timer_d = timer_q;
        if (!active || fifo_empty || pop) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + timer_width_lp'(1);
        end
    end

    always_comb begin
        match_cnt_d    = match_cnt_q;
        mismatch_cnt_d = mismatch_cnt_q;
        fe_exp_d       = fe_exp_q;
        fe_data_d      = fe_data_q;
        unexp_d        = unexp_q | unexp_now;
        timeout_d      = timeout_q | timeout_hit;

        if (match_now && (match_cnt_q != '1)) begin
            match_cnt_d = match_cnt_q + cnt_width_p'(1);
        end
        if (err_now && (mismatch_cnt_q != '1)) begin
            mismatch_cnt_d = mismatch_cnt_q + cnt_width_p'(1);
        end
        // An unexpected response has no expected value, so zero is recorded in its place.
        if (first_err) begin
            fe_exp_d  = unexp_now ? '0 : head_data;
            fe_data_d = resp_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            state_idle_lp: begin
                if (push) begin
                    state_d = state_run_lp;
                end else if (done_i) begin
                    state_d = state_drain_lp;
                end
            end
            state_run_lp: begin
                if (done_i) begin
                    state_d = state_drain_lp;
                end
            end
            state_drain_lp: begin
                if (fifo_empty) begin
                    state_d = ((mismatch_cnt_q != '0) || unexp_q || err_now)
                            ? state_fail_lp : state_pass_lp;
                end
            end
            state_pass_lp: state_d = state_pass_lp;
            state_fail_lp: state_d = state_fail_lp;
            default:       state_d = state_fail_lp;
        endcase

        // Timeout (and stop-on-error) override any same-cycle drain verdict.
        if (active && (timeout_hit || stop_err)) begin
            state_d = state_fail_lp;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= state_idle_lp;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            timer_q        <= '0;
            match_cnt_q    <= '0;
            mismatch_cnt_q <= '0;
            fe_exp_q       <= '0;
            fe_data_q      <= '0;
            unexp_q        <= 1'b0;
            timeout_q      <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            timer_q        <= timer_d;
            match_cnt_q    <= match_cnt_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            fe_exp_q       <= fe_exp_d;
            fe_data_q      <= fe_data_d;
            unexp_q        <= unexp_d;
            timeout_q      <= timeout_d;
            pass_q         <= (state_d == state_pass_lp);
            fail_q         <= (state_d == state_fail_lp);
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone decide which slots are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= exp_data_i;
            mask_mem[wr_ptr_q] <= exp_mask_i;
        end
    end

    assign outstanding_o    = count_q;
    assign match_count_o    = match_cnt_q;
    assign mismatch_count_o = mismatch_cnt_q;
    assign first_err_exp_o  = fe_exp_q;
    assign first_err_data_o = fe_data_q;
    assign unexpected_o     = unexp_q;
    assign timeout_o        = timeout_q;
    assign pass_o           = pass_q;
    assign fail_o           = fail_q;

endmodule
